// File: rtl/calc1_pkg.sv
// calc1_pkg: definitions shared by the calc1 requester-port driver and its FIFO.
//   - command and response code constants of the calc1 core
//   - port-driver FSM state encoding
//   - the 68-bit request entry {cmd, op1, op2} (bit 0 of each field is the MSB)
package calc1_pkg;

    localparam logic [0:3] CMD_NOP = 4'd0;
    localparam logic [0:3] CMD_ADD = 4'd1;
    localparam logic [0:3] CMD_SUB = 4'd2;
    localparam logic [0:3] CMD_SHL = 4'd5;
    localparam logic [0:3] CMD_SHR = 4'd6;

    localparam logic [0:1] RSP_NONE = 2'd0;
    localparam logic [0:1] RSP_OK   = 2'd1;
    localparam logic [0:1] RSP_ERR  = 2'd2;
    localparam logic [0:1] RSP_INT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND1,
        ST_SEND2,
        ST_WAIT,
        ST_DONE
    } calc1_state_t;

    typedef struct packed {
        logic [0:3]  cmd;
        logic [0:31] op1;
        logic [0:31] op2;
    } calc1_req_t;

endpackage

// File: rtl/calc1_req_fifo.sv
// calc1_req_fifo: synchronous request FIFO, DEPTH entries (power of two, >= 2).
// Ports:
//   c_clk      - clock, rising edge
//   reset      - asynchronous active-low; empties the FIFO
//   push       - write push_data (ignored when full)
//   push_data  - request entry to store
//   pop        - drop the head entry (ignored when empty)
//   head       - current head entry, valid whenever empty = 0
//   full/empty - decoded from the occupancy count register
// The head is read asynchronously from the storage array so the driver can
// capture it on the same edge that pops it.
module calc1_req_fifo
    import calc1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       c_clk,
    input  logic       reset,
    input  logic       push,
    input  calc1_req_t push_data,
    input  logic       pop,
    output calc1_req_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    calc1_req_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge c_clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/calc1_port_driver.sv
// calc1_port_driver: request sequencer for one calc1 requester port.
// Buffers complete operations, drives each onto the two-cycle calc1 request
// protocol (cmd+op1, then op2), waits for the port response or a timeout and
// returns the completion on a valid/ready interface.
// Parameters: DEPTH (FIFO entries, power of two >= 2), TIMEOUT (WAIT cycles
// before a timeout completion, >= 2), CNT_W (counter width, 2**CNT_W > TIMEOUT).
// Ports:
//   c_clk, reset                   - clock, async active-low reset
//   in_valid/in_ready/in_cmd/in_op1/in_op2 - upstream operation interface
//   req_cmd_out, req_data_out      - to calc1 reqN_cmd_in / reqN_data_in
//   resp_in, data_in               - from calc1 out_respN / out_dataN
//   rsp_valid/rsp_ready/rsp_code/rsp_data/rsp_timeout - completion interface
//   err_spurious                   - sticky: response seen outside WAIT
module calc1_port_driver
    import calc1_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:3]  in_cmd,
    input  logic [0:31] in_op1,
    input  logic [0:31] in_op2,
    output logic [0:3]  req_cmd_out,
    output logic [0:31] req_data_out,
    input  logic [0:1]  resp_in,
    input  logic [0:31] data_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [0:1]  rsp_code,
    output logic [0:31] rsp_data,
    output logic        rsp_timeout,
    output logic        err_spurious
);

    calc1_state_t state_reg;
    logic [0:31]  op2_reg;
    logic [CNT_W-1:0] cnt_reg;

    calc1_req_t fifo_in;
    calc1_req_t fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;

    assign fifo_in  = '{cmd: in_cmd, op1: in_op1, op2: in_op2};
    assign in_ready = !fifo_full;
    // The only pop point is the IDLE -> SEND1 transition.
    assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty;

    calc1_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .c_clk    (c_clk),
        .reset    (reset),
        .push     (in_valid),
        .push_data(fifo_in),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            op2_reg      <= '0;
            cnt_reg      <= '0;
            req_cmd_out  <= CMD_NOP;
            req_data_out <= '0;
            rsp_valid    <= 1'b0;
            rsp_code     <= RSP_NONE;
            rsp_data     <= '0;
            rsp_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            // Only one request is outstanding, so any response outside WAIT
            // (including a late one after a timeout) is unexpected.
            if (resp_in != RSP_NONE && state_reg != ST_WAIT) begin
                err_spurious <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        op2_reg      <= fifo_head.op2;
                        req_cmd_out  <= fifo_head.cmd;
                        req_data_out <= fifo_head.op1;
                        state_reg    <= ST_SEND1;
                    end
                end
                ST_SEND1: begin
                    req_cmd_out  <= CMD_NOP;
                    req_data_out <= op2_reg;
                    state_reg    <= ST_SEND2;
                end
                ST_SEND2: begin
                    req_data_out <= '0;
                    cnt_reg      <= '0;
                    state_reg    <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    // Response is checked first so it wins a tie with the timeout.
                    if (resp_in != RSP_NONE) begin
                        rsp_valid   <= 1'b1;
                        rsp_code    <= resp_in;
                        rsp_data    <= data_in;
                        rsp_timeout <= 1'b0;
                        state_reg   <= ST_DONE;
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        rsp_valid   <= 1'b1;
                        rsp_code    <= RSP_NONE;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        state_reg   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_port_driver.sv
module tb_calc1_port_driver;
    import calc1_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 8;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [0:3]  in_cmd;
    logic [0:31] in_op1;
    logic [0:31] in_op2;
    logic [0:3]  req_cmd_out;
    logic [0:31] req_data_out;
    logic [0:1]  resp_in;
    logic [0:31] data_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:1]  rsp_code;
    logic [0:31] rsp_data;
    logic        rsp_timeout;
    logic        err_spurious;

    // calc1 port model drives model_*; man_resp injects stray responses.
    logic [0:1]  model_resp;
    logic [0:31] model_data;
    logic [0:1]  man_resp;
    assign resp_in = model_resp | man_resp;
    assign data_in = model_data;

    logic resp_en;
    int   resp_delay;

    typedef struct {
        logic [0:1]  code;
        logic [0:31] data;
        logic        tmo;
    } exp_t;

    exp_t sb_q[$];
    int   send1_q[$];
    int   rise_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    logic prev_valid = 1'b0;

    always #5 c_clk = ~c_clk;

    calc1_port_driver #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cmd      (in_cmd),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .req_cmd_out (req_cmd_out),
        .req_data_out(req_data_out),
        .resp_in     (resp_in),
        .data_in     (data_in),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_code    (rsp_code),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .err_spurious(err_spurious)
    );

    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Monitor: SEND1 / completion timestamps and scoreboard comparison.
    always @(negedge c_clk) begin
        if (req_cmd_out != CMD_NOP) send1_q.push_back(cyc);
        if (rsp_valid && !prev_valid) rise_q.push_back(cyc);
        prev_valid <= rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got completion code=%0d data=0x%0h, required none",
                         rsp_code, rsp_data);
            end else begin
                check("sb_code", rsp_code, sb_q[0].code);
                check("sb_data", rsp_data, sb_q[0].data);
                check("sb_timeout", rsp_timeout, sb_q[0].tmo);
                $display("cyc %0d completion code=%0d data=0x%0h timeout=%0d",
                         cyc, rsp_code, rsp_data, rsp_timeout);
                void'(sb_q.pop_front());
            end
        end
    end

    // calc1 port model: answer each request resp_delay cycles after its SEND2 cycle.
    logic [0:3]  m_cmd;
    logic [0:31] m_op1;
    logic [0:31] m_op2;
    initial begin
        model_resp = 2'd0;
        model_data = '0;
        forever begin
            @(posedge c_clk);
            #1;
            if (resp_en && reset && req_cmd_out != CMD_NOP) begin
                m_cmd = req_cmd_out;
                m_op1 = req_data_out;
                @(posedge c_clk);
                #1;
                m_op2 = req_data_out;
                repeat (resp_delay) @(posedge c_clk);
                #1;
                model_resp = RSP_OK;
                case (m_cmd)
                    CMD_ADD: model_data = m_op1 + m_op2;
                    CMD_SUB: model_data = m_op1 - m_op2;
                    CMD_SHL: model_data = m_op1 << m_op2[27:31];
                    CMD_SHR: model_data = m_op1 >> m_op2[27:31];
                    default: begin
                        model_resp = RSP_ERR;
                        model_data = '0;
                    end
                endcase
                @(posedge c_clk);
                #1;
                model_resp = 2'd0;
                model_data = '0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b,
                        output int acc_cyc);
        int waited;
        in_valid = 1'b1;
        in_cmd   = c;
        in_op1   = a;
        in_op2   = b;
        waited   = 0;
        @(negedge c_clk);
        while (!in_ready && waited < 300) begin
            @(negedge c_clk);
            waited++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL push_accept: got in_ready=0 for 300 cycles, required acceptance");
            acc_cyc = -1000;
            @(posedge c_clk);
            #1;
        end else begin
            @(posedge c_clk);
            #1;
            acc_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_rsp(input logic [0:1] code, input logic [0:31] data, input logic tmo);
        exp_t e;
        e.code = code;
        e.data = data;
        e.tmo  = tmo;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        @(negedge c_clk);
        while ((sb_q.size() != 0 || rsp_valid) && n < max_cyc) begin
            @(negedge c_clk);
            n++;
        end
        if (sb_q.size() != 0 || rsp_valid) begin
            n_total++;
            $display("FAIL %s_drain: got %0d completions pending, required 0", name, sb_q.size());
            sb_q.delete();
        end
        @(posedge c_clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_req_cmd"}, req_cmd_out, 0);
        check({tag, "_req_data"}, req_data_out, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_code"}, rsp_code, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check({tag, "_err_spurious"}, err_spurious, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running at 100000ns, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, acc0, acc4, sq0, rq0, dummy;
        in_valid   = 1'b0;
        in_cmd     = '0;
        in_op1     = '0;
        in_op2     = '0;
        rsp_ready  = 1'b1;
        man_resp   = 2'd0;
        resp_en    = 1'b1;
        resp_delay = 3;

        // Reset state
        repeat (3) @(posedge c_clk);
        #1;
        check_reset_vals("reset");
        @(negedge c_clk);
        reset = 1'b1;
        @(posedge c_clk);
        #1;

        // Add 5 + 3, response 3 cycles after SEND2
        sq0 = send1_q.size();
        rq0 = rise_q.size();
        expect_rsp(RSP_OK, 32'd8, 1'b0);
        push(CMD_ADD, 32'd5, 32'd3, acc);
        @(posedge c_clk);
        #1;
        check("add_send1_cmd", req_cmd_out, 1);
        check("add_send1_data", req_data_out, 5);
        @(posedge c_clk);
        #1;
        check("add_send2_cmd", req_cmd_out, 0);
        check("add_send2_data", req_data_out, 3);
        wait_drain("add", 100);
        check("add_send1_latency", (send1_q.size() > sq0) ? send1_q[sq0] - acc : -1, 1);
        check("add_rsp_latency", (rise_q.size() > rq0) ? rise_q[rq0] - acc : -1, 6);

        // Response on the final WAIT cycle: response wins over timeout
        resp_delay = TIMEOUT;
        rq0 = rise_q.size();
        expect_rsp(RSP_OK, 32'd6, 1'b0);
        push(CMD_SUB, 32'd10, 32'd4, acc);
        wait_drain("tie", 150);
        check("tie_rsp_latency", (rise_q.size() > rq0) ? rise_q[rq0] - acc : -1, 67);

        // Timeout with a silent port, then a late response
        resp_en = 1'b0;
        rq0 = rise_q.size();
        expect_rsp(RSP_NONE, 32'd0, 1'b1);
        push(CMD_SUB, 32'd10, 32'd4, acc);
        wait_drain("timeout", 150);
        check("timeout_latency", (rise_q.size() > rq0) ? rise_q[rq0] - acc : -1, 67);
        check("spurious_before", err_spurious, 0);
        man_resp = RSP_OK;
        @(posedge c_clk);
        #1;
        man_resp = 2'd0;
        @(posedge c_clk);
        #1;
        check("spurious_after", err_spurious, 1);

        // Backpressure: completions stall, FIFO fills after 5 accepts
        resp_en    = 1'b1;
        resp_delay = 2;
        rsp_ready  = 1'b0;
        expect_rsp(RSP_OK, 32'd3, 1'b0);
        push(CMD_ADD, 32'd1, 32'd2, acc0);
        expect_rsp(RSP_OK, 32'd5, 1'b0);
        push(CMD_SUB, 32'd9, 32'd4, dummy);
        expect_rsp(RSP_OK, 32'd16, 1'b0);
        push(CMD_SHL, 32'd1, 32'd4, dummy);
        expect_rsp(RSP_OK, 32'd16, 1'b0);
        push(CMD_SHR, 32'd256, 32'd4, dummy);
        expect_rsp(RSP_OK, 32'd300, 1'b0);
        push(CMD_ADD, 32'd100, 32'd200, acc4);
        check("bp_five_accepts_back_to_back", acc4 - acc0, 4);
        @(negedge c_clk);
        check("bp_in_ready_full", in_ready, 0);
        repeat (8) @(posedge c_clk);
        #1;
        check("bp_in_ready_held", in_ready, 0);
        check("bp_rsp_valid_held", rsp_valid, 1);
        rsp_ready = 1'b1;
        expect_rsp(RSP_ERR, 32'd0, 1'b0);
        push(4'd9, 32'd7, 32'd7, dummy);
        wait_drain("bp", 400);

        // Back-to-back with 1-cycle response: SEND1 every 5 cycles
        resp_delay = 1;
        sq0 = send1_q.size();
        expect_rsp(RSP_OK, 32'd15, 1'b0);
        push(CMD_ADD, 32'd7, 32'd8, dummy);
        expect_rsp(RSP_OK, 32'd12, 1'b0);
        push(CMD_SHL, 32'd3, 32'd2, dummy);
        expect_rsp(RSP_OK, 32'd16, 1'b0);
        push(CMD_SHR, 32'h80, 32'd3, dummy);
        wait_drain("b2b", 100);
        check("b2b_send1_count", send1_q.size() - sq0, 3);
        check("b2b_gap_1", (send1_q.size() > sq0 + 1) ? send1_q[sq0 + 1] - send1_q[sq0] : -1, 5);
        check("b2b_gap_2", (send1_q.size() > sq0 + 2) ? send1_q[sq0 + 2] - send1_q[sq0 + 1] : -1, 5);

        // Reset during SEND2 with two entries queued
        resp_en = 1'b0;
        push(CMD_ADD, 32'd2, 32'd3, dummy);
        push(CMD_SUB, 32'd9, 32'd1, dummy);
        push(CMD_ADD, 32'd4, 32'd4, dummy);
        check("rst_pre_send2_cmd", req_cmd_out, 0);
        check("rst_pre_send2_data", req_data_out, 3);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("rst_async");
        repeat (2) @(posedge c_clk);
        @(negedge c_clk);
        reset = 1'b1;
        sq0 = send1_q.size();
        repeat (12) @(posedge c_clk);
        #1;
        check("rst_no_reissue", send1_q.size() - sq0, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);

        check("sb_leftover", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/calc1_port_driver.md
# calc1_port_driver

Upstream request sequencer for one `calc1` requester port. Accepts complete operations (command plus two operands) on a valid/ready interface, buffers up to `DEPTH` of them, serialises each onto the `calc1` two-cycle request protocol, and waits for that port's response. The response, or a timeout indication, is returned on a downstream valid/ready interface. Four instances, one per port, feed the `calc1` core; only one request per port is ever outstanding at the core.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, at least 2.
- `TIMEOUT`, 64: cycles in WAIT without a response before a timeout completion; at least 2.
- `CNT_W`, 8: width of the timeout counter; must satisfy `2**CNT_W > TIMEOUT`.
- `c_clk` input 1: the only clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `in_valid` input 1: upstream operation present.
- `in_ready` output 1: FIFO not full.
- `in_cmd` input [0:3]: `calc1` command code, forwarded unchecked.
- `in_op1`, `in_op2` input [0:31] each: operands. Bit 0 is the MSB.
- `req_cmd_out` output [0:3]: drives `calc1` `reqN_cmd_in`.
- `req_data_out` output [0:31]: drives `calc1` `reqN_data_in`.
- `resp_in` input [0:1]: from `calc1` `out_respN`.
- `data_in` input [0:31]: from `calc1` `out_dataN`.
- `rsp_valid` output 1: completion present.
- `rsp_ready` input 1: downstream accepts the completion.
- `rsp_code` output [0:1]: captured `resp_in`, or 0 on timeout.
- `rsp_data` output [0:31]: captured `data_in`, or 0 on timeout.
- `rsp_timeout` output 1: the completion is a timeout.
- `err_spurious` output 1: sticky flag. Set when `resp_in` is non-zero in any state other than WAIT. Cleared only by reset.

## Operation
- FIFO push on `in_valid && in_ready`. Each entry holds {cmd, op1, op2}, 68 bits. The FIFO pops only on the IDLE→SEND1 transition.
- FSM states: IDLE, SEND1, SEND2, WAIT, DONE.
  - IDLE: outputs cmd=0, data=0. If the FIFO is non-empty: pop the head into the holding register and go to SEND1.
  - SEND1: `req_cmd_out`=cmd, `req_data_out`=op1. Always go to SEND2.
  - SEND2: `req_cmd_out`=0, `req_data_out`=op2. Always go to WAIT and clear the counter.
  - WAIT: cmd=0, data=0, counter increments each cycle.
    - If `resp_in` != 0: capture code and data, assert `rsp_valid`, `rsp_timeout`=0, go to DONE.
    - Else if counter == TIMEOUT-1: `rsp_valid`=1, code=0, data=0, `rsp_timeout`=1, go to DONE.
  - DONE: hold all `rsp_*` outputs stable. When `rsp_ready`=1, drop `rsp_valid` and go to IDLE.
- A response and the timeout in the same WAIT cycle: the response wins, `rsp_timeout`=0.
- A late response after a timeout is flagged via `err_spurious` and is not delivered.
- Push and pop in the same cycle are both legal. `in_ready` reflects the pre-edge occupancy, so a full FIFO accepts nothing in that cycle even if it pops.
- Commands are not range-checked; invalid codes go to `calc1`, which answers with resp 2.

## Timing
- Reset values: `in_ready`=1, `req_cmd_out`=0, `req_data_out`=0, `rsp_valid`=0, `rsp_code`=0, `rsp_data`=0, `rsp_timeout`=0, `err_spurious`=0. FSM=IDLE, FIFO empty.
- Reset asserted mid-operation aborts the in-flight request. Request outputs go to 0 immediately (asynchronously). Queued entries are discarded.
- Latency with an empty FIFO, operation accepted at edge E0:
  - SEND1 is visible after E1 (cmd + op1).
  - SEND2 after E2 (op2).
  - WAIT from E3.
  - A response sampled at edge Ek gives `rsp_valid`=1 after Ek.
- Minimum issue interval between requests: 5 cycles (SEND1, SEND2, WAIT ≥1, DONE ≥1, IDLE 1).
- All outputs are registered; there is no combinational path from inputs to outputs except `in_ready`, which derives from the FIFO count register only.

## Structure
- Shared package `calc1_pkg`:
  - command constants `CMD_NOP`=0, `CMD_ADD`=1, `CMD_SUB`=2, `CMD_SHL`=5, `CMD_SHR`=6;
  - response constants `RSP_NONE`=0, `RSP_OK`=1, `RSP_ERR`=2, `RSP_INT`=3;
  - the FSM state enum;
  - the 68-bit request struct.
- One sub-module: `calc1_req_fifo` (synchronous FIFO, parameter `DEPTH`, count-based full/empty, async active-low reset). It is instantiated once.

## Test plan
- Add 5 + 3: push {1, 5, 3}. Response model returns resp 1, data 8, three cycles after SEND2. Required: `req_cmd_out` 1 then 0; `req_data_out` 5 then 3; `rsp_valid` with code 1, data 8, `rsp_timeout`=0.
- Timeout: push {2, 10, 4} with the model silent and TIMEOUT=64. Required: `rsp_valid` exactly 64 cycles after WAIT entry, with code 0, data 0, `rsp_timeout`=1. A later resp 1 sets `err_spurious`.
- Backpressure: hold `rsp_ready`=0 and push 6 operations with DEPTH=4. Required: `in_ready` drops after the 5th accept (4 queued plus 1 in flight). Completions emerge in order once `rsp_ready`=1.
- Response/timeout tie: response arrives on the counter==TIMEOUT-1 cycle. Required: code from `resp_in`, `rsp_timeout`=0.
- Reset mid-operation: deassert `reset` during SEND2 with 2 entries queued. Required: all outputs at reset values at once. After release, no request is reissued and `in_ready`=1.
- Back-to-back: 3 queued operations with `rsp_ready` tied to 1 and a fixed 1-cycle response delay. Required: consecutive SEND1 cycles spaced exactly 5 cycles apart.
